// File: rtl/qoi_encoder.sv
// qoi_encoder: streaming QOI encoder, one pixel in and one complete opcode out per beat.
// Pipeline: input register -> hash/table-read register -> encoder + output register.
// Optional feature macro: QOI_ENCODER_ALPHA_EN (alpha channel and the RGBA opcode).
module qoi_encoder #(
  parameter int MAX_RUN        = 62,
  parameter bit OPT_LINE_RESET = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        s_vid_valid,
  output logic        s_vid_ready,
  input  logic [31:0] s_vid_data,
  input  logic        s_vid_hlast,
  input  logic        s_vid_vlast,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [39:0] m_data,
  output logic [2:0]  m_bytes,
  output logic        m_last
);

  typedef enum logic {ACCEPT, FLUSH} state_t;

  localparam logic [31:0] PREV_INIT = 32'hFF00_0000;
  localparam logic [5:0]  RUN_CAP   = 6'(MAX_RUN);

  state_t       state_reg, state_next;
  logic [31:0]  prev_reg;
  logic [5:0]   run_reg, run_next;
  logic [63:0]  valid_vec_reg;

  logic         v1_reg, hl1_reg, vl1_reg;
  logic [31:0]  px1_reg;
  logic [5:0]   idx1;
  logic         v2_reg, hl2_reg, vl2_reg, rv2_reg, byp2_reg;
  logic [31:0]  px2_reg, bypd2_reg, tbl_q, tbl_rd;
  logic [5:0]   idx2_reg;
  logic [31:0]  tbl_mem [64];

  logic [31:0]  in_px;
  logic         out_free, match_prev, brk, pipe_en, frame_end, seg_end;
  logic         emit, tok_last, wr_en, clr, wr_hit;
  logic [39:0]  tok_data, pix_data;
  logic [2:0]   tok_bytes, pix_bytes;
  logic [7:0]   dr, dg, db, dr_o, dg_o, db_o, dg_l, rg_l, bg_l;

`ifdef QOI_ENCODER_ALPHA_EN
  assign in_px = s_vid_data;
`else
  // Alpha is pinned opaque; the incoming alpha byte is deliberately ignored.
  logic unused_alpha;
  assign unused_alpha = ^s_vid_data[31:24];
  assign in_px = {8'hFF, s_vid_data[23:0]};
`endif

  function automatic logic [5:0] qoi_hash(input logic [31:0] p);
    logic [11:0] s;
    s = 12'(p[23:16]) * 12'd3 + 12'(p[15:8]) * 12'd5
      + 12'(p[7:0]) * 12'd7 + 12'(p[31:24]) * 12'd11;
    return s[5:0];
  endfunction

  assign idx1       = qoi_hash(px1_reg);
  assign out_free   = !m_valid || m_ready;
  assign match_prev = (px2_reg == prev_reg);
  // A run broken by a new pixel costs one beat: the RUN token goes out while the pixel waits.
  assign brk        = (state_reg == ACCEPT) && v2_reg && !match_prev && (run_reg != 6'd0);
  assign pipe_en    = out_free && !brk;
  assign s_vid_ready = i_reset_n && pipe_en;
  assign frame_end  = hl2_reg && vl2_reg;
  assign seg_end    = hl2_reg && (vl2_reg || OPT_LINE_RESET);
  assign wr_hit     = wr_en && (idx2_reg == idx1);
  // Invalid entries read as zero; a same-cycle write to the looked-up slot is forwarded.
  assign tbl_rd     = !rv2_reg ? 32'h0 : (byp2_reg ? bypd2_reg : tbl_q);

  // Stage 1: capture the accepted pixel.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v1_reg  <= 1'b0;
      px1_reg <= '0;
      hl1_reg <= 1'b0;
      vl1_reg <= 1'b0;
    end else if (pipe_en) begin
      v1_reg  <= s_vid_valid;
      px1_reg <= in_px;
      hl1_reg <= s_vid_hlast;
      vl1_reg <= s_vid_vlast;
    end
  end

  // Stage 2: hash result plus validity/forwarding info for the registered table read.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      v2_reg    <= 1'b0;
      px2_reg   <= '0;
      idx2_reg  <= '0;
      hl2_reg   <= 1'b0;
      vl2_reg   <= 1'b0;
      rv2_reg   <= 1'b0;
      byp2_reg  <= 1'b0;
      bypd2_reg <= '0;
    end else if (pipe_en) begin
      v2_reg    <= v1_reg;
      px2_reg   <= px1_reg;
      idx2_reg  <= idx1;
      hl2_reg   <= hl1_reg;
      vl2_reg   <= vl1_reg;
      rv2_reg   <= clr ? 1'b0 : (wr_hit ? 1'b1 : valid_vec_reg[idx1]);
      byp2_reg  <= wr_hit;
      bypd2_reg <= px2_reg;
    end
  end

  // Index table storage with registered read.
  always_ff @(posedge i_clk) begin
    if (wr_en) tbl_mem[idx2_reg] <= px2_reg;
    if (pipe_en) tbl_q <= tbl_mem[idx1];
  end

  // Choose the non-RUN opcode for the pixel in stage 2.
  always_comb begin
    dr   = px2_reg[23:16] - prev_reg[23:16];
    dg   = px2_reg[15:8]  - prev_reg[15:8];
    db   = px2_reg[7:0]   - prev_reg[7:0];
    dr_o = dr + 8'd2;
    dg_o = dg + 8'd2;
    db_o = db + 8'd2;
    dg_l = dg + 8'd32;
    rg_l = dr - dg + 8'd8;
    bg_l = db - dg + 8'd8;
    pix_data  = {8'hFE, px2_reg[23:0], 8'h00};
    pix_bytes = 3'd4;
    if (tbl_rd == px2_reg) begin
      pix_data  = {2'b00, idx2_reg, 32'h0};
      pix_bytes = 3'd1;
    end
`ifdef QOI_ENCODER_ALPHA_EN
    else if (px2_reg[31:24] != prev_reg[31:24]) begin
      pix_data  = {8'hFF, px2_reg[23:0], px2_reg[31:24]};
      pix_bytes = 3'd5;
    end
`endif
    else if (dr_o < 8'd4 && dg_o < 8'd4 && db_o < 8'd4) begin
      pix_data  = {2'b01, dr_o[1:0], dg_o[1:0], db_o[1:0], 32'h0};
      pix_bytes = 3'd1;
    end else if (dg_l < 8'd64 && rg_l < 8'd16 && bg_l < 8'd16) begin
      pix_data  = {2'b10, dg_l[5:0], rg_l[3:0], bg_l[3:0], 24'h0};
      pix_bytes = 3'd2;
    end
  end

  // Encoder FSM next state: run accounting, token selection and state updates.
  always_comb begin
    state_next = state_reg;
    run_next   = run_reg;
    emit       = 1'b0;
    tok_data   = '0;
    tok_bytes  = 3'd0;
    tok_last   = 1'b0;
    wr_en      = 1'b0;
    clr        = 1'b0;
    if (v2_reg && out_free) begin
      if (state_reg == FLUSH || (!match_prev && run_reg == 6'd0)) begin
        emit       = 1'b1;
        tok_data   = pix_data;
        tok_bytes  = pix_bytes;
        tok_last   = frame_end;
        wr_en      = 1'b1;
        clr        = seg_end;
        state_next = ACCEPT;
      end else if (match_prev) begin
        if (run_reg + 6'd1 == RUN_CAP || seg_end) begin
          emit      = 1'b1;
          tok_data  = {2'b11, run_reg, 32'h0};
          tok_bytes = 3'd1;
          tok_last  = frame_end;
          clr       = seg_end;
          run_next  = 6'd0;
        end else begin
          run_next = run_reg + 6'd1;
        end
      end else begin
        emit       = 1'b1;
        tok_data   = {2'b11, run_reg - 6'd1, 32'h0};
        tok_bytes  = 3'd1;
        run_next   = 6'd0;
        state_next = FLUSH;
      end
    end
  end

  // Encoder state: FSM, run count, previous pixel and table valid bits.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_reg     <= ACCEPT;
      run_reg       <= 6'd0;
      prev_reg      <= PREV_INIT;
      valid_vec_reg <= '0;
    end else begin
      state_reg <= state_next;
      run_reg   <= run_next;
      if (clr) begin
        prev_reg      <= PREV_INIT;
        valid_vec_reg <= '0;
      end else if (wr_en) begin
        prev_reg                <= px2_reg;
        valid_vec_reg[idx2_reg] <= 1'b1;
      end
    end
  end

  // Output register; holds its contents while the sink stalls.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_bytes <= '0;
      m_last  <= 1'b0;
    end else if (out_free) begin
      m_valid <= emit;
      if (emit) begin
        m_data  <= tok_data;
        m_bytes <= tok_bytes;
        m_last  <= tok_last;
      end
    end
  end

endmodule

// File: tb/tb_qoi_encoder.sv
// tb_qoi_encoder: directed-vector bench for qoi_encoder with hand-computed tokens.
module tb_qoi_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        s_vid_valid, s_vid_ready, s_vid_hlast, s_vid_vlast;
  logic [31:0] s_vid_data;
  logic        m_valid, m_ready, m_last;
  logic [39:0] m_data;
  logic [2:0]  m_bytes;

  typedef struct { logic [31:0] d; logic hl; logic vl; } px_t;
  typedef struct { logic [39:0] d; logic [2:0] b; logic l; } tok_t;

  px_t  px_q[$];
  tok_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  qoi_encoder #(.MAX_RUN(62), .OPT_LINE_RESET(1'b0)) dut (
    .i_clk      (clk),
    .i_reset_n  (rst_n),
    .s_vid_valid(s_vid_valid),
    .s_vid_ready(s_vid_ready),
    .s_vid_data (s_vid_data),
    .s_vid_hlast(s_vid_hlast),
    .s_vid_vlast(s_vid_vlast),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_bytes    (m_bytes),
    .m_last     (m_last)
  );

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic add_px(input logic [7:0] a, input logic [7:0] r, input logic [7:0] g,
                        input logic [7:0] b, input logic hl, input logic vl);
    px_t p;
    p.d = {a, r, g, b}; p.hl = hl; p.vl = vl;
    px_q.push_back(p);
  endtask

  task automatic add_tok(input logic [39:0] d, input logic [2:0] b, input logic l);
    tok_t t;
    t.d = d; t.b = b; t.l = l;
    exp_q.push_back(t);
  endtask

  // Streams px_q in, collects tokens against exp_q, optionally stalls the sink
  // for stall_len cycles once the first token shows up.
  task automatic run_test(input string name, input int stall_len,
                          input int exp_ready_low, input int exp_lat);
    int   pi, got, ready_low, hs_cyc, first_v, stall_left, n_exp, n_px, limit;
    bit   stall_pend;
    tok_t t;
    pi = 0; got = 0; ready_low = 0; hs_cyc = -1; first_v = -1; stall_left = 0;
    stall_pend = (stall_len > 0);
    n_exp = exp_q.size();
    n_px  = px_q.size();
    limit = n_px + stall_len + 12;
    for (int cyc = 0; cyc < limit; cyc++) begin
      @(negedge clk);
      if (stall_pend && m_valid) begin
        stall_left = stall_len;
        stall_pend = 1'b0;
      end
      m_ready = (stall_left == 0);
      if (stall_left > 0) begin
        stall_left--;
        check({name, ":hold_valid"}, 40'(m_valid), 40'd1);
        if (exp_q.size() > 0) begin
          check({name, ":hold_data"}, m_data, exp_q[0].d);
          check({name, ":hold_bytes"}, 40'(m_bytes), 40'(exp_q[0].b));
        end
      end
      if (pi < n_px) begin
        s_vid_valid = 1'b1;
        s_vid_data  = px_q[pi].d;
        s_vid_hlast = px_q[pi].hl;
        s_vid_vlast = px_q[pi].vl;
      end else begin
        s_vid_valid = 1'b0;
        s_vid_data  = '0;
        s_vid_hlast = 1'b0;
        s_vid_vlast = 1'b0;
      end
      #1;
      if (m_ready && !s_vid_ready) ready_low++;
      if (s_vid_valid && s_vid_ready) begin
        if (pi == 0) hs_cyc = cyc;
        pi++;
      end
      if (m_valid && first_v < 0) first_v = cyc;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check({name, ":extra_token"}, 40'(got + 1), 40'(n_exp));
        end else begin
          t = exp_q.pop_front();
          $display("[%s] token %0d: data=%h bytes=%0d last=%0d", name, got, m_data, m_bytes, m_last);
          check({name, ":data"}, m_data, t.d);
          check({name, ":bytes"}, 40'(m_bytes), 40'(t.b));
          check({name, ":last"}, 40'(m_last), 40'(t.l));
          got++;
        end
      end
    end
    m_ready = 1'b1;
    check({name, ":pixels_taken"}, 40'(pi), 40'(n_px));
    check({name, ":token_count"}, 40'(got), 40'(n_exp));
    check({name, ":ready_low_cycles"}, 40'(ready_low), 40'(exp_ready_low));
    if (exp_lat > 0) check({name, ":latency"}, 40'(first_v - hs_cyc), 40'(exp_lat));
    px_q.delete();
    exp_q.delete();
  endtask

  initial begin
    rst_n = 1'b0;
    s_vid_valid = 1'b0; s_vid_data = '0; s_vid_hlast = 1'b0; s_vid_vlast = 1'b0;
    m_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("reset:m_valid", 40'(m_valid), 40'd0);
    check("reset:m_data", m_data, 40'd0);
    check("reset:m_bytes", 40'(m_bytes), 40'd0);
    check("reset:m_last", 40'(m_last), 40'd0);
    check("reset:s_vid_ready", 40'(s_vid_ready), 40'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // RGB token, also measures handshake-to-valid latency
    add_px(8'hFF, 8'd10, 8'd20, 8'd30, 1'b1, 1'b1);
    add_tok(40'hFE0A141E00, 3'd4, 1'b1);
    run_test("rgb", 0, 0, 3);

    // DIFF, DIFF, INDEX (hash 4)
    add_px(8'hFF, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0);
    add_px(8'hFF, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    add_px(8'hFF, 8'd1, 8'd1, 8'd1, 1'b1, 1'b1);
    add_tok(40'h7F00000000, 3'd1, 1'b0);
    add_tok(40'h5500000000, 3'd1, 1'b0);
    add_tok(40'h0400000000, 3'd1, 1'b1);
    run_test("index", 0, 0, 0);

    // LUMA
    add_px(8'hFF, 8'd10, 8'd12, 8'd14, 1'b1, 1'b1);
    add_tok(40'hAC6A000000, 3'd2, 1'b1);
    run_test("luma", 0, 0, 0);

    // 70-pixel run split at MAX_RUN, with a 5-cycle sink stall
    for (int i = 0; i < 70; i++) add_px(8'hFF, 8'd0, 8'd0, 8'd0, i == 69, i == 69);
    add_tok(40'hFD00000000, 3'd1, 1'b0);
    add_tok(40'hC700000000, 3'd1, 1'b1);
    run_test("run_cap", 5, 0, 0);

    // run broken by a new pixel: one-cycle input bubble
    for (int i = 0; i < 3; i++) add_px(8'hFF, 8'd0, 8'd0, 8'd0, 1'b0, 1'b0);
    add_px(8'hFF, 8'd1, 8'd1, 8'd1, 1'b1, 1'b1);
    add_tok(40'hC200000000, 3'd1, 1'b0);
    add_tok(40'h7F00000000, 3'd1, 1'b1);
    run_test("run_break", 0, 1, 0);

    // alpha change
    add_px(8'd128, 8'd0, 8'd0, 8'd0, 1'b1, 1'b1);
`ifdef QOI_ENCODER_ALPHA_EN
    add_tok(40'hFF00000080, 3'd5, 1'b1);
`else
    add_tok(40'hC000000000, 3'd1, 1'b1);
`endif
    run_test("alpha", 0, 0, 0);

    // line end without line reset keeps state; run flushed only at frame end
    add_px(8'hFF, 8'd1, 8'd1, 8'd1, 1'b1, 1'b0);
    add_px(8'hFF, 8'd1, 8'd1, 8'd1, 1'b1, 1'b1);
    add_tok(40'h7F00000000, 3'd1, 1'b0);
    add_tok(40'hC000000000, 3'd1, 1'b1);
    run_test("line", 0, 0, 0);

    // state cleared at frame end: same pixel again is DIFF, not RUN/INDEX
    add_px(8'hFF, 8'd1, 8'd1, 8'd1, 1'b1, 1'b1);
    add_tok(40'h7F00000000, 3'd1, 1'b0 | 1'b1);
    run_test("frame_clear", 0, 0, 0);

    // adjacent same-hash overwrite: X, Y(hash 4), X must not hit the index
    add_px(8'hFF, 8'd1, 8'd1, 8'd1, 1'b0, 1'b0);
    add_px(8'hFF, 8'd5, 8'd0, 8'd0, 1'b0, 1'b0);
    add_px(8'hFF, 8'd1, 8'd1, 8'd1, 1'b1, 1'b1);
    add_tok(40'h7F00000000, 3'd1, 1'b0);
    add_tok(40'h9FD8000000, 3'd2, 1'b0);
    add_tok(40'hA138000000, 3'd2, 1'b1);
    run_test("hash_hazard", 0, 0, 0);

    // reset mid-frame discards in-flight pixels and state
    @(negedge clk);
    s_vid_valid = 1'b1; s_vid_data = 32'hFF010101; s_vid_hlast = 1'b0; s_vid_vlast = 1'b0;
    @(negedge clk);
    s_vid_data = 32'hFF050505;
    @(negedge clk);
    s_vid_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midreset:m_valid", 40'(m_valid), 40'd0);
    check("midreset:s_vid_ready", 40'(s_vid_ready), 40'd0);
    repeat (2) @(negedge clk);
    check("midreset:m_valid_held", 40'(m_valid), 40'd0);
    rst_n = 1'b1;
    add_px(8'hFF, 8'd10, 8'd12, 8'd14, 1'b1, 1'b1);
    add_tok(40'hAC6A000000, 3'd2, 1'b1);
    run_test("after_reset", 0, 0, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
